alpha_div_sched: RTL and testbench
==================================

# alpha_div_sched

Round-robin scheduler and sequencer for one shared fractional divider that computes the haze-removal transmission ratio alpha = dark_diff / denom as a 7-bit binary fraction. Up to NREQ pixel lanes request a division. The block grants one lane at a time, runs a restoring division at one quotient bit per cycle, and returns the result tagged with the lane index. It sits between the per-lane dark-channel difference stage and the transmission/recovery stage, so those lanes share a single divider datapath.

## Interface
- NREQ, 4, number of requesting lanes (2..8)
- W, 8, operand width of dark_diff and denom
- FW, 7, fraction bits of alpha
- clk  in  1  rising-edge clock; the only clock in the block
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-lane request
- req_ready  out  NREQ  per-lane accept; at most one bit is high in any cycle
- req_dark_diff  in  NREQ*W  lane i occupies bits [i*W +: W]
- req_denom  in  NREQ*W  lane i occupies bits [i*W +: W]
- rsp_valid  out  1  result available
- rsp_ready  in  1  downstream accept
- rsp_id  out  clog2(NREQ)  index of the lane that owns the result
- rsp_alpha  out  FW  quotient fraction
- rsp_sat  out  1  dark_diff >= denom and denom != 0
- rsp_dz  out  1  denom == 0

## Operation
- States: IDLE, DIV, RSP.
- **IDLE**
  - The winner is the first lane with req_valid high, searching upward from ptr and wrapping modulo NREQ.
  - req_ready is asserted combinationally for the winner only. All other req_ready bits are 0.
  - A handshake (req_valid & req_ready) latches the winner's operands and id.
  - After a handshake, ptr is set to (winner+1) mod NREQ.
- **Routing after a handshake**
  - If denom == 0: alpha = all-ones, dz = 1, next state RSP.
  - Else if dark_diff >= denom: alpha = all-ones, sat = 1, next state RSP.
  - Otherwise: next state DIV, with temp = dark_diff << 1 and bit counter = FW-1.
- **Division arithmetic**
  - temp is W+2 bits wide and cannot overflow, because dark_diff < denom.
  - Each DIV cycle produces one quotient bit, MSB first: alpha[k].
  - For k = FW-1 down to 1: alpha[k] = (temp >= denom). Then temp = (alpha[k] ? temp - denom : temp) << 1.
  - The final bit uses a strict compare: alpha[0] = (temp > denom). This rule is required so that results are bit-exact with the existing combinational alpha unit.
  - After alpha[0] is resolved, next state is RSP.
- **RSP**
  - rsp_valid = 1. rsp_id, rsp_alpha, rsp_sat and rsp_dz are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, next state is IDLE.
- **Flow rules**
  - No new request is accepted in DIV or RSP; req_ready is all-zero there.
  - Requesters must hold req_valid and operands stable until accepted.
  - A request that drops before being accepted is never serviced.

## Timing
- A handshake in cycle T on the DIV path gives quotient bits in cycles T+1..T+FW and rsp_valid from cycle T+FW+1. This is 8 cycles with the defaults.
- On the saturate and divide-by-zero paths, rsp_valid is asserted from cycle T+1.
- The earliest next grant is the cycle after the rsp handshake.
- Peak throughput with defaults: one result per FW+2 = 9 cycles.
- rsp_ready held low stalls the block indefinitely in RSP. Outputs do not change during the stall.
- rsp_valid does not depend combinationally on rsp_ready.
- Reset (asynchronous assert, synchronous-safe deassert):
  - state = IDLE, ptr = 0, rsp_valid = 0.
  - rsp_id, rsp_alpha, rsp_sat and rsp_dz are 0.
  - req_ready is 0 while rst_n is low.
- Reset during DIV or RSP discards the in-flight result immediately. No rsp_valid pulse follows, and the first grant after reset goes to the lowest valid lane.
- ptr wraps from NREQ-1 to 0.

## Test plan
- **Basic divisions (lane 0 only):** with dark_diff = 10 and denom = 30 -> rsp_alpha = 0x2A, rsp_id = 0, rsp_valid 8 cycles after the handshake. Then 100/150 -> 0x55, and 100/200 -> 0x40.
- **Strict final compare:** 1/128 -> rsp_alpha = 0x00. Final temp equals 128, which must not set bit 0.
- **Edge cases:**
  - 150/100 -> rsp_alpha = 0x7F, rsp_sat = 1, rsp_valid 1 cycle after the handshake.
  - 5/0 -> rsp_alpha = 0x7F, rsp_dz = 1, rsp_sat = 0.
- **Round-robin fairness:** all four lanes valid continuously from reset -> grant order 0, 1, 2, 3, 0. Exactly one req_ready bit is high in each IDLE cycle, and each result carries the matching rsp_id.
- **Backpressure:** rsp_ready held low for 20 cycles -> rsp_valid and data remain stable with no new grant. rsp_ready high for one cycle -> IDLE on the next cycle.
- **Reset mid-division:** rst_n pulsed low 3 cycles into DIV -> rsp_valid = 0 immediately. After release with lanes 2 and 3 valid, lane 2 is granted first.

Source files
------------

// File: rtl/alpha_div_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : alpha_div_sched_if
// Description : Request/response bundle between pixel lanes, the shared
//               alpha divider scheduler and the downstream transmission stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alpha_div_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int FW   = 7
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_dark_diff;
    logic [NREQ*W-1:0] req_denom;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [FW-1:0]     rsp_alpha;
    logic              rsp_sat;
    logic              rsp_dz;

    // Lanes and the downstream consumer
    modport master (
        output req_valid, req_dark_diff, req_denom, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_alpha, rsp_sat, rsp_dz
    );

    // The scheduler itself
    modport slave (
        input  req_valid, req_dark_diff, req_denom, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_alpha, rsp_sat, rsp_dz
    );
endinterface
`default_nettype wire

// File: rtl/alpha_div_sched.sv
`default_nettype none
// ============================================================================
// Module      : alpha_div_sched
// Description : Round-robin arbiter feeding one bit-serial restoring divider
//               that produces alpha = dark_diff / denom as an FW-bit fraction,
//               tagged with the id of the requesting lane.
// Revision    : 1.0 - initial release
// ============================================================================
module alpha_div_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int FW   = 7
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    alpha_div_sched_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(FW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [W+1:0]    temp_q, temp_d;
    logic [W-1:0]    denom_q, denom_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   alpha_q, alpha_d;
    logic            sat_q, sat_d;
    logic            dz_q, dz_d;
    logic            valid_q, valid_d;

    logic            w_found;
    logic [IDW-1:0]  w_winner;
    logic [IDW-1:0]  w_scan;
    logic [W-1:0]    w_dd;
    logic [W-1:0]    w_dn;
    logic            w_hs;
    logic [W+1:0]    w_denom_ext;
    logic            w_ge;
    logic            w_gt;

    // Round-robin search: first valid lane at or above ptr, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        for (int off = 0; off < NREQ; off++) begin
            w_scan = IDW'((int'(ptr_q) + off) % NREQ);
            if (!w_found && bus.req_valid[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan;
            end
        end
    end

    // Operand mux for the winning lane (constant slices keep the mux explicit)
    always_comb begin
        w_dd = '0;
        w_dn = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == IDW'(i)) begin
                w_dd = bus.req_dark_diff[i*W +: W];
                w_dn = bus.req_denom[i*W +: W];
            end
        end
    end

    // rst_n gating keeps req_ready low for the whole reset window
    assign w_hs          = (state_q == IDLE) && w_found && rst_n;
    assign bus.req_ready = w_hs ? (NREQ'(1) << w_winner) : '0;

    assign w_denom_ext = {2'b00, denom_q};
    assign w_ge        = (temp_q >= w_denom_ext);
    // Last bit uses a strict compare to stay bit-exact with the legacy
    // combinational alpha unit
    assign w_gt        = (temp_q > w_denom_ext);

    // Next-state logic for the scheduler FSM and the divider datapath
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        temp_d  = temp_q;
        denom_d = denom_q;
        cnt_d   = cnt_q;
        alpha_d = alpha_q;
        sat_d   = sat_q;
        dz_d    = dz_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (w_hs) begin
                    id_d    = w_winner;
                    ptr_d   = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
                    denom_d = w_dn;
                    alpha_d = '0;
                    sat_d   = 1'b0;
                    dz_d    = 1'b0;
                    if (w_dn == '0) begin
                        alpha_d = '1;
                        dz_d    = 1'b1;
                        valid_d = 1'b1;
                        state_d = RSP;
                    end else if (w_dd >= w_dn) begin
                        alpha_d = '1;
                        sat_d   = 1'b1;
                        valid_d = 1'b1;
                        state_d = RSP;
                    end else begin
                        // dark_diff < denom, so 2*temp never exceeds W+2 bits
                        temp_d  = {2'b00, w_dd} << 1;
                        cnt_d   = CW'(FW - 1);
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                if (cnt_q == '0) begin
                    alpha_d[0] = w_gt;
                    valid_d    = 1'b1;
                    state_d    = RSP;
                end else begin
                    alpha_d[cnt_q] = w_ge;
                    temp_d         = (w_ge ? (temp_q - w_denom_ext) : temp_q) << 1;
                    cnt_d          = cnt_q - 1'b1;
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset drops any in-flight division
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            temp_q  <= '0;
            denom_q <= '0;
            cnt_q   <= '0;
            alpha_q <= '0;
            sat_q   <= 1'b0;
            dz_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            temp_q  <= temp_d;
            denom_q <= denom_d;
            cnt_q   <= cnt_d;
            alpha_q <= alpha_d;
            sat_q   <= sat_d;
            dz_q    <= dz_d;
            valid_q <= valid_d;
        end
    end

    assign bus.rsp_valid = valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_alpha = alpha_q;
    assign bus.rsp_sat   = sat_q;
    assign bus.rsp_dz    = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_alpha_div_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alpha_div_sched
// Description : Scoreboard bench for the shared alpha divider scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alpha_div_sched;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int FW   = 7;
    localparam int ONES = (1 << FW) - 1;

    typedef struct {
        int id;
        int alpha;
        int sat;
        int dz;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alpha_div_sched_if #(.NREQ(NREQ), .W(W), .FW(FW)) bus ();

    alpha_div_sched #(.NREQ(NREQ), .W(W), .FW(FW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   grants[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t mon_e;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(int id, int alpha, int sat, int dz);
        exp_t e;
        e.id = id; e.alpha = alpha; e.sat = sat; e.dz = dz;
        return e;
    endfunction

    // Reference: floor(dd*2^FW/dn), except an exact odd quotient loses its
    // LSB because the final bit is decided by a strict compare
    function automatic exp_t model(int id, int dd, int dn);
        int q;
        if (dn == 0)        return mk(id, ONES, 0, 1);
        else if (dd >= dn)  return mk(id, ONES, 1, 0);
        q = (dd << FW) / dn;
        if (((dd << FW) % dn == 0) && (q % 2 == 1)) q = q - 1;
        return mk(id, q, 0, 0);
    endfunction

    // Monitor: grants, one-hot ready, and scoreboard pops on rsp handshake
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
            for (int i = 0; i < NREQ; i++)
                if (bus.req_valid[i] && bus.req_ready[i]) grants.push_back(i);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("rsp_id",    32'(bus.rsp_id),    mon_e.id);
                    check_eq("rsp_alpha", 32'(bus.rsp_alpha), mon_e.alpha);
                    check_eq("rsp_sat",   32'(bus.rsp_sat),   mon_e.sat);
                    check_eq("rsp_dz",    32'(bus.rsp_dz),    mon_e.dz);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lane(input int lane, input int dd, input int dn, input logic v);
        bus.req_dark_diff[lane*W +: W] = W'(dd);
        bus.req_denom[lane*W +: W]     = W'(dn);
        bus.req_valid[lane]            = v;
    endtask

    task automatic wait_grants(input int n, input int bound);
        int c = 0;
        while (grants.size() < n && c < bound) begin tick(); c++; end
        check_eq("grant_count_to", 32'(grants.size() >= n), 32'd1);
    endtask

    task automatic wait_drain(input int bound);
        int c = 0;
        while ((sb.size() != 0 || bus.rsp_valid) && c < bound) begin tick(); c++; end
        check_eq("drain_to", 32'(sb.size()), 32'd0);
    endtask

    // One request on an otherwise quiet bus, with latency measured in cycles
    task automatic run_one(input int lane, input int dd, input int dn, input exp_t e, input int exp_lat);
        int n;
        int lat;
        sb.push_back(e);
        drive_lane(lane, dd, dn, 1'b1);
        #1;
        n = 0;
        while (!bus.req_ready[lane] && n < 50) begin tick(); n++; end
        check_eq("grant", 32'(bus.req_ready[lane]), 32'd1);
        tick();
        bus.req_valid[lane] = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin tick(); lat++; end
        check_eq("latency", lat, exp_lat);
        wait_drain(20);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   dd;
        int   dn;
        int   ln;
        exp_t e;

        bus.req_valid     = '0;
        bus.req_dark_diff = '0;
        bus.req_denom     = '0;
        bus.rsp_ready     = 1'b1;

        // Fairness set-up: all lanes valid while held in reset
        for (int i = 0; i < NREQ; i++) begin
            dd = (i == 3) ? 7  : 20 * (i + 1);
            dn = (i == 3) ? 0  : 30;
            drive_lane(i, dd, dn, 1'b1);
        end
        repeat (3) tick();
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
        check_eq("rst_rsp_alpha", 32'(bus.rsp_alpha), 32'd0);
        check_eq("rst_sat_dz",    32'({bus.rsp_sat, bus.rsp_dz}), 32'd0);
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);

        sb.push_back(model(0, 20, 30));
        sb.push_back(model(1, 40, 30));
        sb.push_back(model(2, 60, 30));
        sb.push_back(model(3, 7, 0));
        sb.push_back(model(0, 20, 30));
        rst_n = 1'b1;
        wait_grants(5, 120);
        bus.req_valid = '0;
        check_eq("rr_order_0", grants.size() > 0 ? grants[0] : -1, 0);
        check_eq("rr_order_1", grants.size() > 1 ? grants[1] : -1, 1);
        check_eq("rr_order_2", grants.size() > 2 ? grants[2] : -1, 2);
        check_eq("rr_order_3", grants.size() > 3 ? grants[3] : -1, 3);
        check_eq("rr_order_4", grants.size() > 4 ? grants[4] : -1, 0);
        wait_drain(40);

        // Directed divisions and edge cases
        run_one(0, 10, 30,   mk(0, 'h2A, 0, 0), 8);
        run_one(0, 100, 150, mk(0, 'h55, 0, 0), 8);
        run_one(0, 100, 200, mk(0, 'h40, 0, 0), 8);
        run_one(0, 1, 128,   mk(0, 'h00, 0, 0), 8);
        run_one(0, 150, 100, mk(0, 'h7F, 1, 0), 1);
        run_one(0, 5, 0,     mk(0, 'h7F, 0, 1), 1);

        // Backpressure: lane 1 result stalls while lane 0 waits
        bus.rsp_ready = 1'b0;
        sb.push_back(mk(1, 'h55, 0, 0));
        drive_lane(1, 100, 150, 1'b1);
        #1;
        n = 0;
        while (!bus.req_ready[1] && n < 50) begin tick(); n++; end
        check_eq("bp_grant", 32'(bus.req_ready[1]), 32'd1);
        tick();
        bus.req_valid[1] = 1'b0;
        sb.push_back(model(0, 30, 60));
        drive_lane(0, 30, 60, 1'b1);
        n = 0;
        while (!bus.rsp_valid && n < 40) begin tick(); n++; end
        for (int c = 0; c < 20; c++) begin
            check_eq("bp_stall",
                     32'({bus.rsp_valid, bus.rsp_id, bus.rsp_alpha, bus.rsp_sat, bus.rsp_dz, bus.req_ready}),
                     32'({1'b1, 2'd1, 7'h55, 1'b0, 1'b0, 4'b0000}));
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        check_eq("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("bp_release_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        bus.req_valid[0] = 1'b0;
        wait_drain(40);

        // Randomised single-lane requests against the reference
        for (int r = 0; r < 8; r++) begin
            ln = int'($urandom_range(NREQ - 1, 0));
            dn = int'($urandom_range(255, 1));
            dd = int'($urandom_range(dn - 1, 0));
            e  = model(ln, dd, dn);
            run_one(ln, dd, dn, e, 8);
        end

        // Reset three cycles into a division
        drive_lane(0, 10, 30, 1'b1);
        #1;
        n = 0;
        while (!bus.req_ready[0] && n < 50) begin tick(); n++; end
        check_eq("mid_grant", 32'(bus.req_ready[0]), 32'd1);
        tick();
        bus.req_valid[0] = 1'b0;
        tick();
        tick();
        drive_lane(2, 50, 100, 1'b1);
        drive_lane(3, 5, 0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        tick();
        grants.delete();
        sb.push_back(mk(2, 'h40, 0, 0));
        sb.push_back(mk(3, 'h7F, 0, 1));
        rst_n = 1'b1;
        wait_grants(2, 60);
        bus.req_valid = '0;
        check_eq("post_rst_first", grants.size() > 0 ? grants[0] : -1, 2);
        check_eq("post_rst_second", grants.size() > 1 ? grants[1] : -1, 3);
        wait_drain(40);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
